// File: rtl/eth_loopback_responder.sv
// eth_loopback_responder
//
// Echoes Ethernet frames back to their sender. A frame whose destination is
// LOCAL_MAC (or broadcast) and whose ethertype is ETH_TYPE is buffered, then
// replayed with the source MAC as the new destination and LOCAL_MAC as the
// new source. Frames that do not match, overflow the buffer, or end with
// tuser=1 are consumed and counted as drops.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   s_eth_hdr_*                  receive header (valid/ready, dest, src, type)
//   s_eth_payload_axis_*         receive payload stream (tdata/tvalid/tready/tlast/tuser)
//   m_eth_hdr_*                  transmit header (valid/ready, dest, src, type)
//   m_eth_payload_axis_*         transmit payload stream
//   rx_frame_count               frames accepted for echo (saturating)
//   tx_frame_count               frames fully echoed (saturating)
//   drop_count                   frames discarded (saturating)
//   busy                         high whenever the FSM is not idle
//
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid and ready are both high. Once valid is raised it stays high,
// with its data unchanged, until that edge; ready may change at any time.
module eth_loopback_responder #(
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_00,
  parameter logic [15:0] ETH_TYPE   = 16'h88B5,
  parameter int          MAX_LEN    = 512,
  parameter int          DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic [15:0]           rx_frame_count,
  output logic [15:0]           tx_frame_count,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  localparam int          AW     = $clog2(MAX_LEN);
  localparam logic [AW-1:0] WR_END = AW'(MAX_LEN - 1);
  localparam logic [AW:0]   ONE    = (AW+1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_DROP,
    ST_TX_HDR,
    ST_TX_PAYLOAD
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] buf_mem [MAX_LEN];
  logic [AW-1:0]         wr_ptr;
  logic [AW:0]           frame_len;
  logic [AW:0]           tx_idx;
  logic [47:0]           reply_dest;

  logic hdr_fire, rx_fire, hdr_match;
  logic m_hdr_fire, tx_load, tx_last_fire;

  assign hdr_fire     = s_eth_hdr_valid && s_eth_hdr_ready;
  assign rx_fire      = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
  assign hdr_match    = ((s_eth_dest_mac == LOCAL_MAC) || (s_eth_dest_mac == 48'hFFFF_FFFF_FFFF))
                        && (s_eth_type == ETH_TYPE);
  assign m_hdr_fire   = m_eth_hdr_valid && m_eth_hdr_ready;
  // The output beat register refills whenever it is empty or being drained,
  // so a continuously ready sink sees one byte per cycle.
  assign tx_load      = (state == ST_TX_PAYLOAD) && (tx_idx != frame_len)
                        && (!m_eth_payload_axis_tvalid || m_eth_payload_axis_tready);
  assign tx_last_fire = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready
                        && m_eth_payload_axis_tlast;

  assign m_eth_payload_axis_tuser = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (hdr_fire) state_next = hdr_match ? ST_RX : ST_DROP;
      ST_RX: begin
        if (rx_fire) begin
          if (s_eth_payload_axis_tlast)
            state_next = s_eth_payload_axis_tuser ? ST_IDLE : ST_TX_HDR;
          else if (wr_ptr == WR_END)
            state_next = ST_DROP;  // buffer full and the frame keeps going
        end
      end
      ST_DROP:       if (rx_fire && s_eth_payload_axis_tlast) state_next = ST_IDLE;
      ST_TX_HDR:     if (m_hdr_fire) state_next = ST_TX_PAYLOAD;
      ST_TX_PAYLOAD: if (tx_last_fire) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  // Payload storage has no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if ((state == ST_RX) && rx_fire) buf_mem[wr_ptr] <= s_eth_payload_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_eth_hdr_ready           <= 1'b0;
      s_eth_payload_axis_tready <= 1'b0;
      busy                      <= 1'b0;
      m_eth_hdr_valid           <= 1'b0;
      m_eth_dest_mac            <= '0;
      m_eth_src_mac             <= '0;
      m_eth_type                <= '0;
      m_eth_payload_axis_tdata  <= '0;
      m_eth_payload_axis_tvalid <= 1'b0;
      m_eth_payload_axis_tlast  <= 1'b0;
      rx_frame_count            <= '0;
      tx_frame_count            <= '0;
      drop_count                <= '0;
      wr_ptr                    <= '0;
      frame_len                 <= '0;
      tx_idx                    <= '0;
      reply_dest                <= '0;
    end else begin
      // Ready and busy are registered copies of what the next state implies.
      s_eth_hdr_ready           <= (state_next == ST_IDLE);
      s_eth_payload_axis_tready <= (state_next == ST_RX) || (state_next == ST_DROP);
      busy                      <= (state_next != ST_IDLE);

      if ((state == ST_IDLE) && hdr_fire) begin
        reply_dest <= s_eth_src_mac;
        wr_ptr     <= '0;
      end

      if ((state == ST_RX) && rx_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (s_eth_payload_axis_tlast) begin
          if (!s_eth_payload_axis_tuser) begin
            frame_len <= {1'b0, wr_ptr} + ONE;
            if (rx_frame_count != 16'hFFFF) rx_frame_count <= rx_frame_count + 1'b1;
          end else if (drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 1'b1;
          end
        end
      end

      if ((state == ST_DROP) && rx_fire && s_eth_payload_axis_tlast
          && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 1'b1;

      if ((state == ST_RX) && (state_next == ST_TX_HDR)) begin
        m_eth_hdr_valid <= 1'b1;
        m_eth_dest_mac  <= reply_dest;
        m_eth_src_mac   <= LOCAL_MAC;
        m_eth_type      <= ETH_TYPE;
      end else if ((state == ST_TX_HDR) && m_hdr_fire) begin
        m_eth_hdr_valid <= 1'b0;
        tx_idx          <= '0;
      end

      if (tx_last_fire) begin
        m_eth_payload_axis_tvalid <= 1'b0;
        m_eth_payload_axis_tlast  <= 1'b0;
        if (tx_frame_count != 16'hFFFF) tx_frame_count <= tx_frame_count + 1'b1;
      end else if (tx_load) begin
        m_eth_payload_axis_tvalid <= 1'b1;
        m_eth_payload_axis_tdata  <= buf_mem[tx_idx[AW-1:0]];
        m_eth_payload_axis_tlast  <= (tx_idx == frame_len - ONE);
        tx_idx                    <= tx_idx + ONE;
      end else if (m_eth_payload_axis_tvalid && m_eth_payload_axis_tready) begin
        m_eth_payload_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
